// File: rtl/picorv32_mem_arbiter_pkg.sv
// Types and constants shared by the picorv32 two-master SRAM arbiter.
package picorv32_mem_pkg;
  localparam int MEM_WORD_W = 32;
  localparam int WSTRB_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAM  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Full 30-bit word index compare; high address bits never alias into the array.
  function automatic logic out_of_range(input logic [31:0] addr, input int mem_words);
    return {2'b00, addr[31:2]} >= 32'(mem_words);
  endfunction
endpackage

// File: rtl/picorv32_mem_arbiter_if.sv
// Bus bundle: two picorv32 native memory masters plus the shared SRAM port.
interface picorv32_mem_arbiter_if #(parameter int AW = 12);
  import picorv32_mem_pkg::*;

  logic                  m0_valid, m1_valid;
  logic [31:0]           m0_addr,  m1_addr;
  logic [MEM_WORD_W-1:0] m0_wdata, m1_wdata;
  logic [WSTRB_W-1:0]    m0_wstrb, m1_wstrb;
  logic                  m0_ready, m1_ready;
  logic [MEM_WORD_W-1:0] m0_rdata, m1_rdata;

  logic                  ram_en;
  logic [WSTRB_W-1:0]    ram_wstrb;
  logic [AW-1:0]         ram_addr;
  logic [MEM_WORD_W-1:0] ram_wdata;
  logic [MEM_WORD_W-1:0] ram_rdata;

  logic                  grant;
  logic                  busy;
  logic                  err;

  modport slave (
    input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
    input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
    input  ram_rdata,
    output m0_ready, m0_rdata, m1_ready, m1_rdata,
    output ram_en, ram_wstrb, ram_addr, ram_wdata,
    output grant, busy, err
  );

  modport master (
    output m0_valid, m0_addr, m0_wdata, m0_wstrb,
    output m1_valid, m1_addr, m1_wdata, m1_wstrb,
    output ram_rdata,
    input  m0_ready, m0_rdata, m1_ready, m1_rdata,
    input  ram_en, ram_wstrb, ram_addr, ram_wdata,
    input  grant, busy, err
  );
endinterface

// File: rtl/picorv32_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the master that did not win last time goes.
module picorv32_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_vld,
  output logic       gnt_idx
);
  assign gnt_vld = |req;
  assign gnt_idx = (&req) ? ~last_grant : req[1];
endmodule

// File: rtl/picorv32_mem_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency SRAM between two picorv32 masters.
module picorv32_mem_arbiter
  import picorv32_mem_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int AW        = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  picorv32_mem_arbiter_if.slave  bus
);
  state_e                state;
  logic                  last_grant, grant_q;
  logic                  oor_q, rd_ok_q;
  logic                  ready0_q, ready1_q, err_q;
  logic                  ram_en_q;
  logic [WSTRB_W-1:0]    ram_wstrb_q;
  logic [AW-1:0]         ram_addr_q;
  logic [MEM_WORD_W-1:0] ram_wdata_q;

  logic                  gnt_vld, gnt_idx;
  logic [31:0]           sel_addr;
  logic [MEM_WORD_W-1:0] sel_wdata;
  logic [WSTRB_W-1:0]    sel_wstrb;
  logic                  sel_oor;

  picorv32_rr_arb2 u_arb (
    .req        ({bus.m1_valid, bus.m0_valid}),
    .last_grant (last_grant),
    .gnt_vld    (gnt_vld),
    .gnt_idx    (gnt_idx)
  );

  assign sel_addr  = gnt_idx ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = gnt_idx ? bus.m1_wdata : bus.m0_wdata;
  assign sel_wstrb = gnt_idx ? bus.m1_wstrb : bus.m0_wstrb;
  assign sel_oor   = out_of_range(sel_addr, MEM_WORDS);

  // SRAM-side fields are loaded straight from the winner in IDLE, so the
  // request is frozen for the whole access regardless of what the master does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant_q     <= 1'b0;
      oor_q       <= 1'b0;
      rd_ok_q     <= 1'b0;
      ready0_q    <= 1'b0;
      ready1_q    <= 1'b0;
      err_q       <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_wstrb_q <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          grant_q     <= gnt_idx;
          oor_q       <= sel_oor;
          rd_ok_q     <= (sel_wstrb == '0) && !sel_oor;
          ram_en_q    <= !sel_oor;
          ram_wstrb_q <= sel_oor ? '0 : sel_wstrb;
          ram_addr_q  <= sel_oor ? '0 : sel_addr[AW+1:2];
          ram_wdata_q <= sel_oor ? '0 : sel_wdata;
          state       <= RAM;
        end
        RAM: begin
          ram_en_q    <= 1'b0;
          ram_wstrb_q <= '0;
          ram_addr_q  <= '0;
          ram_wdata_q <= '0;
          ready0_q    <= !grant_q;
          ready1_q    <= grant_q;
          err_q       <= oor_q;
          state       <= RESP;
        end
        RESP: begin
          ready0_q    <= 1'b0;
          ready1_q    <= 1'b0;
          err_q       <= 1'b0;
          last_grant  <= grant_q;
          grant_q     <= 1'b0;
          oor_q       <= 1'b0;
          rd_ok_q     <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_wstrb = ram_wstrb_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state != IDLE);
  assign bus.err       = err_q;
  assign bus.m0_ready  = ready0_q;
  assign bus.m1_ready  = ready1_q;
  // SRAM data arrives during RESP, so read data is steered combinationally.
  assign bus.m0_rdata  = (ready0_q && rd_ok_q) ? bus.ram_rdata : '0;
  assign bus.m1_rdata  = (ready1_q && rd_ok_q) ? bus.ram_rdata : '0;
endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Bench: transaction-level model checked every cycle plus directed literal expectations.
module tb_picorv32_mem_arbiter;
  localparam int MW = 4096;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  picorv32_mem_arbiter_if #(.AW(12)) bus();
  picorv32_mem_arbiter #(.MEM_WORDS(MW), .AW(12)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Environment SRAM, zero-initialised, one cycle read latency.
  logic [31:0] sram [0:MW-1];
  initial for (int i = 0; i < MW; i++) sram[i] = '0;
  always @(posedge clk) if (bus.ram_en) begin
    if (bus.ram_wstrb == 4'b0) bus.ram_rdata <= sram[bus.ram_addr];
    for (int b = 0; b < 4; b++)
      if (bus.ram_wstrb[b]) sram[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
  end

  // Model: each accepted request occupies three cycles (accept, SRAM, response).
  typedef struct {
    int          m;
    int          en_cyc, rdy_cyc;
    logic        en;
    logic [3:0]  wstrb;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        err;
  } rec_t;
  rec_t log_q[$];

  logic [31:0] shadow [int];
  int          ph = 0;
  logic        mlast = 1'b1;
  int          cm;
  logic [31:0] ca, cd;
  logic [3:0]  cs;
  logic        coor;
  rec_t        cur;

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},  bus.busy, 0);
    chk({tag, "_grant"}, bus.grant, 0);
    chk({tag, "_en"},    bus.ram_en, 0);
    chk({tag, "_wstrb"}, bus.ram_wstrb, 0);
    chk({tag, "_rdy0"},  bus.m0_ready, 0);
    chk({tag, "_rdy1"},  bus.m1_ready, 0);
    chk({tag, "_rd0"},   bus.m0_rdata, 0);
    chk({tag, "_rd1"},   bus.m1_rdata, 0);
    chk({tag, "_err"},   bus.err, 0);
  endtask

  always @(negedge clk) begin
    logic [31:0] exp_rd, w;
    int          wi;
    cyc++;
    chk("one_ready", bus.m0_ready & bus.m1_ready, 0);
    if (reset) begin
      ph = 0; mlast = 1'b1;
      chk_quiet("rst");
    end else if (ph == 0) begin
      chk_quiet("idle");
      if (bus.m0_valid || bus.m1_valid) begin
        cm   = (bus.m0_valid && bus.m1_valid) ? int'(!mlast) : (bus.m1_valid ? 1 : 0);
        ca   = cm ? bus.m1_addr  : bus.m0_addr;
        cd   = cm ? bus.m1_wdata : bus.m0_wdata;
        cs   = cm ? bus.m1_wstrb : bus.m0_wstrb;
        coor = (ca / 4) >= MW;
        ph   = 1;
      end
    end else if (ph == 1) begin
      chk("ram_busy",  bus.busy, 1);
      chk("ram_grant", bus.grant, cm);
      chk("ram_en",    bus.ram_en, !coor);
      chk("ram_wstrb", bus.ram_wstrb, coor ? 4'b0 : cs);
      if (!coor) begin
        chk("ram_addr",  bus.ram_addr, ca / 4);
        chk("ram_wdata", bus.ram_wdata, cd);
      end
      chk("ram_rdy", {bus.m1_ready, bus.m0_ready}, 0);
      chk("ram_err", bus.err, 0);
      cur.m = cm; cur.en_cyc = cyc; cur.en = bus.ram_en;
      cur.wstrb = bus.ram_wstrb; cur.addr = bus.ram_addr;
      ph = 2;
    end else begin
      wi = int'(ca / 4);
      exp_rd = (cs == 4'b0 && !coor && shadow.exists(wi)) ? shadow[wi] : 32'h0;
      chk("rsp_busy",  bus.busy, 1);
      chk("rsp_grant", bus.grant, cm);
      chk("rsp_rdy0",  bus.m0_ready, cm == 0);
      chk("rsp_rdy1",  bus.m1_ready, cm == 1);
      chk("rsp_rd0",   bus.m0_rdata, cm == 0 ? exp_rd : 32'h0);
      chk("rsp_rd1",   bus.m1_rdata, cm == 1 ? exp_rd : 32'h0);
      chk("rsp_err",   bus.err, coor);
      chk("rsp_en",    bus.ram_en, 0);
      cur.rdy_cyc = cyc;
      cur.rdata = cm ? bus.m1_rdata : bus.m0_rdata;
      cur.err = bus.err;
      log_q.push_back(cur);
      if (cs != 4'b0 && !coor) begin
        w = shadow.exists(wi) ? shadow[wi] : 32'h0;
        for (int b = 0; b < 4; b++) if (cs[b]) w[8*b +: 8] = cd[8*b +: 8];
        shadow[wi] = w;
      end
      mlast = cm[0];
      ph = 0;
    end
  end

  // Picorv32-style master: hold valid until ready, bounded wait.
  task automatic req(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit got = 0;
    if (m == 0) begin bus.m0_valid = 1; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_wstrb = s; end
    else        begin bus.m1_valid = 1; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_wstrb = s; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (m == 0) ? bus.m0_ready : bus.m1_ready;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL req_timeout m%0d addr %h: no ready within 20 cycles", m, a); end
    @(posedge clk); #1;
    if (m == 0) bus.m0_valid = 0; else bus.m1_valid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, s, k;
    bus.m0_valid = 0; bus.m0_addr = 0; bus.m0_wdata = 0; bus.m0_wstrb = 0;
    bus.m1_valid = 0; bus.m1_addr = 0; bus.m1_wdata = 0; bus.m1_wstrb = 0;
    bus.ram_rdata = 0;
    reset = 1;

    // 1: both requesting during reset; m0 wins first after release
    bus.m0_valid = 1; bus.m0_addr = 32'h20;
    bus.m1_valid = 1; bus.m1_addr = 32'h24;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 0; rel = cyc;
    fork
      req(0, 32'h20, 0, 4'b0);
      req(1, 32'h24, 0, 4'b0);
    join
    chk("t1_first_m",   log_q[0].m, 0);
    chk("t1_en_cyc",    log_q[0].en_cyc, rel + 2);
    chk("t1_rdy_cyc",   log_q[0].rdy_cyc, rel + 3);
    chk("t1_second_m",  log_q[1].m, 1);
    chk("t1_second_rdy", log_q[1].rdy_cyc, rel + 6);

    // 2: byte-masked write then read back
    req(0, 32'h10, 32'hA5A5_1234, 4'b0101);
    chk("t2_ram_addr",  log_q[$].addr, 12'd4);
    chk("t2_ram_wstrb", log_q[$].wstrb, 4'b0101);
    req(0, 32'h10, 0, 4'b0);
    chk("t2_rdata", log_q[$].rdata, 32'h00A5_0034);

    // 3: continuous contention alternates, one completion every 3 cycles
    s = log_q.size();
    fork
      for (int i = 0; i < 4; i++) req(0, 32'h10, 0, 4'b0);
      for (int i = 0; i < 4; i++) req(1, 32'h100 + 4 * i, 0, 4'b0);
    join
    chk("t3_count", log_q.size() - s, 8);
    for (int i = 0; i < 8 && s + i < log_q.size(); i++) begin
      chk("t3_alt", log_q[s+i].m, (i % 2 == 0) ? 1 : 0);
      if (i > 0) chk("t3_spacing", log_q[s+i].rdy_cyc - log_q[s+i-1].rdy_cyc, 3);
    end

    // 4: out of range, boundary word, and no wrap of high addresses
    req(1, 32'h0000_4000, 0, 4'b0);
    chk("t4_en",    log_q[$].en, 0);
    chk("t4_err",   log_q[$].err, 1);
    chk("t4_rdata", log_q[$].rdata, 0);
    req(1, 32'h0000_4000, 32'hFFFF_FFFF, 4'hF);
    req(0, 32'h0, 0, 4'b0);
    chk("t4_word0_rd",  log_q[$].rdata, 0);
    chk("t4_word0_ram", sram[0], 0);
    req(1, 32'hFFFF_FFFC, 32'h1, 4'hF);
    chk("t4_hi_err", log_q[$].err, 1);
    req(1, 32'h0000_3FFC, 32'hCAFE_F00D, 4'hF);
    chk("t4_last_err", log_q[$].err, 0);
    req(0, 32'h0000_3FFD, 0, 4'b0);
    chk("t4_last_rd", log_q[$].rdata, 32'hCAFE_F00D);

    // 5: reset in RAM state aborts; the held request then completes
    s = log_q.size();
    fork
      req(0, 32'h10, 0, 4'b0);
      begin
        k = 0;
        do begin @(negedge clk); k++; end while (!bus.ram_en && k < 10);
        chk("t5_saw_ram", bus.ram_en, 1);
        #2 reset = 1;
        #1;
        chk("t5_en_async", bus.ram_en, 0);
        chk("t5_busy_async", bus.busy, 0);
        @(posedge clk); @(negedge clk);
        chk("t5_no_ready", log_q.size(), s);
        @(posedge clk); #1 reset = 0; rel = cyc;
      end
    join
    chk("t5_done",    log_q.size(), s + 1);
    chk("t5_rdy_cyc", log_q[$].rdy_cyc, rel + 3);
    chk("t5_rdata",   log_q[$].rdata, 32'h00A5_0034);

    // 6: valid dropped during RAM still gets its ready pulse
    s = log_q.size();
    @(posedge clk); #1;
    bus.m0_valid = 1; bus.m0_addr = 32'h3FFC; bus.m0_wstrb = 4'b0;
    @(negedge clk);
    @(posedge clk); #1 bus.m0_valid = 0;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.m0_ready && k < 10);
    chk("t6_ready", bus.m0_ready, 1);
    chk("t6_rdata", bus.m0_rdata, 32'hCAFE_F00D);
    @(negedge clk);
    chk("t6_idle", bus.busy, 0);
    chk("t6_logged", log_q.size(), s + 1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
